// File: rtl/axi_mux_arbiter.sv
// axi_mux_arbiter: N-master AXI3 read/write arbiter onto one port.
// Registered round-robin grants, per-master read credit, write ownership.
module axi_mux_arbiter #(
  parameter int N_RD     = 2,
  parameter int N_WR     = 2,
  parameter int MAX_OUTS = 2,
  parameter int ID_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  // read masters
  input  logic [N_RD*32-1:0]   m_araddr,
  input  logic [N_RD*4-1:0]    m_arlen,
  input  logic [N_RD*3-1:0]    m_arsize,
  input  logic [N_RD-1:0]      m_arvalid,
  output logic [N_RD-1:0]      m_arready,
  output logic [N_RD*32-1:0]   m_rdata,
  output logic [N_RD-1:0]      m_rlast,
  output logic [N_RD-1:0]      m_rvalid,
  input  logic [N_RD-1:0]      m_rready,
  // write masters
  input  logic [N_WR*32-1:0]   m_awaddr,
  input  logic [N_WR*4-1:0]    m_awlen,
  input  logic [N_WR*3-1:0]    m_awsize,
  input  logic [N_WR-1:0]      m_awvalid,
  output logic [N_WR-1:0]      m_awready,
  input  logic [N_WR*32-1:0]   m_wdata,
  input  logic [N_WR*4-1:0]    m_wstrb,
  input  logic [N_WR-1:0]      m_wlast,
  input  logic [N_WR-1:0]      m_wvalid,
  output logic [N_WR-1:0]      m_wready,
  output logic [N_WR-1:0]      m_bvalid,
  input  logic [N_WR-1:0]      m_bready,
  // AXI AR
  output logic [ID_W-1:0]      arid,
  output logic [31:0]          araddr,
  output logic [3:0]           arlen,
  output logic [2:0]           arsize,
  output logic [1:0]           arburst,
  output logic [1:0]           arlock,
  output logic [3:0]           arcache,
  output logic [2:0]           arprot,
  output logic                 arvalid,
  input  logic                 arready,
  // AXI R
  input  logic [ID_W-1:0]      rid,
  input  logic [31:0]          rdata,
  input  logic [1:0]           rresp,
  input  logic                 rlast,
  input  logic                 rvalid,
  output logic                 rready,
  // AXI AW
  output logic [ID_W-1:0]      awid,
  output logic [31:0]          awaddr,
  output logic [3:0]           awlen,
  output logic [2:0]           awsize,
  output logic [1:0]           awburst,
  output logic [1:0]           awlock,
  output logic [3:0]           awcache,
  output logic [2:0]           awprot,
  output logic                 awvalid,
  input  logic                 awready,
  // AXI W
  output logic [ID_W-1:0]      wid,
  output logic [31:0]          wdata,
  output logic [3:0]           wstrb,
  output logic                 wlast,
  output logic                 wvalid,
  input  logic                 wready,
  // AXI B
  input  logic [ID_W-1:0]      bid,
  input  logic [1:0]           bresp,
  input  logic                 bvalid,
  output logic                 bready
);

  localparam int RGW = (N_RD > 1) ? $clog2(N_RD) : 1;
  localparam int WGW = (N_WR > 1) ? $clog2(N_WR) : 1;

  typedef enum logic {RA_IDLE, RA_BUSY} ra_state_t;
  typedef enum logic [1:0] {
    W_IDLE, W_ADDR, W_DATA, W_RESP
  } w_state_t;

  ra_state_t        r_ra_state;
  logic [RGW-1:0]   r_ar_gnt;
  logic [RGW-1:0]   r_rr_rd;
  logic [3:0]       r_rd_cnt [N_RD];

  w_state_t         r_w_state;
  logic [WGW-1:0]   r_wr_gnt;
  logic [WGW-1:0]   r_rr_wr;

  logic [N_RD-1:0]  w_rd_elig;
  logic             w_rd_found;
  logic [RGW-1:0]   w_rd_pick;
  logic [N_RD-1:0]  w_ar_sel;
  logic             w_ar_any;
  logic [31:0]      w_araddr;
  logic [3:0]       w_arlen;
  logic [2:0]       w_arsize;
  logic             w_ar_hs;
  logic [RGW-1:0]   w_rr_rd_nxt;

  logic [N_RD-1:0]  w_rsel;
  logic             w_rsel_rdy;
  logic             w_r_done;
  logic [N_RD-1:0]  w_cnt_inc;
  logic [N_RD-1:0]  w_cnt_dec;

  logic             w_wr_found;
  logic [WGW-1:0]   w_wr_pick;
  logic [N_WR-1:0]  w_wr_sel;
  logic             w_aw_any;
  logic             w_w_any;
  logic             w_b_rdy;
  logic [31:0]      w_awaddr;
  logic [3:0]       w_awlen;
  logic [2:0]       w_awsize;
  logic [31:0]      w_wdata;
  logic [3:0]       w_wstrb;
  logic             w_wlast;
  logic             w_aw_hs;
  logic             w_w_end;
  logic             w_b_hs;
  logic [WGW-1:0]   w_rr_wr_nxt;

  logic             w_unused;

  assign w_unused = ^{rresp, bresp, bid};

  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

  // Read round-robin: first eligible master at or after r_rr_rd.
  always_comb begin
    w_rd_elig  = '0;
    w_rd_found = 1'b0;
    w_rd_pick  = '0;
    for (int k = 0; k < N_RD; k++) begin
      w_rd_elig[k] = m_arvalid[k] &&
                     (r_rd_cnt[k] < 4'(MAX_OUTS));
    end
    for (int k = 0; k < N_RD; k++) begin
      if (!w_rd_found && w_rd_elig[k] &&
          (RGW'(k) >= r_rr_rd)) begin
        w_rd_found = 1'b1;
        w_rd_pick  = RGW'(k);
      end
    end
    for (int k = 0; k < N_RD; k++) begin
      if (!w_rd_found && w_rd_elig[k]) begin
        w_rd_found = 1'b1;
        w_rd_pick  = RGW'(k);
      end
    end
  end

  // AR mux driven from the registered read grant.
  always_comb begin
    w_ar_sel = '0;
    w_ar_any = 1'b0;
    w_araddr = '0;
    w_arlen  = '0;
    w_arsize = '0;
    for (int k = 0; k < N_RD; k++) begin
      w_ar_sel[k] = (r_ar_gnt == RGW'(k));
      if (w_ar_sel[k]) begin
        w_ar_any = m_arvalid[k];
        w_araddr = m_araddr[k*32 +: 32];
        w_arlen  = m_arlen[k*4 +: 4];
        w_arsize = m_arsize[k*3 +: 3];
      end
    end
  end

  assign arvalid   = (r_ra_state == RA_BUSY) && w_ar_any;
  assign araddr    = w_araddr;
  assign arlen     = w_arlen;
  assign arsize    = w_arsize;
  assign arid      = ID_W'(r_ar_gnt);
  assign w_ar_hs   = arvalid && arready;
  assign m_arready = w_ar_hs ? w_ar_sel : '0;

  assign w_rr_rd_nxt = (r_ar_gnt == RGW'(N_RD - 1)) ?
                       '0 : r_ar_gnt + 1'b1;

  // Read arbiter FSM: grant held from selection to AR handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ra_state <= RA_IDLE;
      r_ar_gnt   <= '0;
      r_rr_rd    <= '0;
    end else begin
      case (r_ra_state)
        RA_IDLE: begin
          if (w_rd_found) begin
            r_ar_gnt   <= w_rd_pick;
            r_ra_state <= RA_BUSY;
          end
        end
        RA_BUSY: begin
          if (w_ar_hs) begin
            r_rr_rd    <= w_rr_rd_nxt;
            r_ra_state <= RA_IDLE;
          end
        end
        default: r_ra_state <= RA_IDLE;
      endcase
    end
  end

  // R routing by rid; unknown ids are sunk with rready high.
  always_comb begin
    w_rsel     = '0;
    w_rsel_rdy = 1'b0;
    m_rvalid   = '0;
    m_rdata    = '0;
    m_rlast    = '0;
    for (int k = 0; k < N_RD; k++) begin
      w_rsel[k] = (rid == ID_W'(k));
      if (w_rsel[k]) begin
        m_rvalid[k]          = rvalid;
        m_rdata[k*32 +: 32]  = rdata;
        m_rlast[k]           = rlast;
        w_rsel_rdy           = m_rready[k];
      end
    end
    rready = (|w_rsel) ? w_rsel_rdy : 1'b1;
  end

  assign w_r_done  = rvalid && rready && rlast && (|w_rsel);
  assign w_cnt_inc = w_ar_hs ? w_ar_sel : '0;
  assign w_cnt_dec = w_r_done ? w_rsel : '0;

  // Outstanding-read credit per master.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N_RD; k++) r_rd_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < N_RD; k++) begin
        if (w_cnt_inc[k] && !w_cnt_dec[k])
          r_rd_cnt[k] <= r_rd_cnt[k] + 4'd1;
        else if (w_cnt_dec[k] && !w_cnt_inc[k])
          r_rd_cnt[k] <= r_rd_cnt[k] - 4'd1;
      end
    end
  end

  // Write round-robin: first requester at or after r_rr_wr.
  always_comb begin
    w_wr_found = 1'b0;
    w_wr_pick  = '0;
    for (int k = 0; k < N_WR; k++) begin
      if (!w_wr_found && m_awvalid[k] &&
          (WGW'(k) >= r_rr_wr)) begin
        w_wr_found = 1'b1;
        w_wr_pick  = WGW'(k);
      end
    end
    for (int k = 0; k < N_WR; k++) begin
      if (!w_wr_found && m_awvalid[k]) begin
        w_wr_found = 1'b1;
        w_wr_pick  = WGW'(k);
      end
    end
  end

  // AW/W/B mux driven from the registered write owner.
  always_comb begin
    w_wr_sel = '0;
    w_aw_any = 1'b0;
    w_w_any  = 1'b0;
    w_b_rdy  = 1'b0;
    w_awaddr = '0;
    w_awlen  = '0;
    w_awsize = '0;
    w_wdata  = '0;
    w_wstrb  = '0;
    w_wlast  = 1'b0;
    for (int k = 0; k < N_WR; k++) begin
      w_wr_sel[k] = (r_wr_gnt == WGW'(k));
      if (w_wr_sel[k]) begin
        w_aw_any = m_awvalid[k];
        w_w_any  = m_wvalid[k];
        w_b_rdy  = m_bready[k];
        w_awaddr = m_awaddr[k*32 +: 32];
        w_awlen  = m_awlen[k*4 +: 4];
        w_awsize = m_awsize[k*3 +: 3];
        w_wdata  = m_wdata[k*32 +: 32];
        w_wstrb  = m_wstrb[k*4 +: 4];
        w_wlast  = m_wlast[k];
      end
    end
  end

  assign awid    = ID_W'(r_wr_gnt);
  assign wid     = awid;
  assign awaddr  = w_awaddr;
  assign awlen   = w_awlen;
  assign awsize  = w_awsize;
  assign wdata   = w_wdata;
  assign wstrb   = w_wstrb;
  assign wlast   = w_wlast;

  assign awvalid = (r_w_state == W_ADDR) && w_aw_any;
  assign wvalid  = (r_w_state == W_DATA) && w_w_any;
  assign bready  = (r_w_state == W_RESP) && w_b_rdy;

  assign w_aw_hs = awvalid && awready;
  assign w_w_end = wvalid && wready && wlast;
  assign w_b_hs  = bvalid && bready;

  assign m_awready = w_aw_hs ? w_wr_sel : '0;
  assign m_wready  = ((r_w_state == W_DATA) && wready) ?
                     w_wr_sel : '0;
  assign m_bvalid  = ((r_w_state == W_RESP) && bvalid) ?
                     w_wr_sel : '0;

  assign w_rr_wr_nxt = (r_wr_gnt == WGW'(N_WR - 1)) ?
                       '0 : r_wr_gnt + 1'b1;

  // Write FSM: owner kept from AW selection until B completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_w_state <= W_IDLE;
      r_wr_gnt  <= '0;
      r_rr_wr   <= '0;
    end else begin
      case (r_w_state)
        W_IDLE: begin
          if (w_wr_found) begin
            r_wr_gnt  <= w_wr_pick;
            r_w_state <= W_ADDR;
          end
        end
        W_ADDR: if (w_aw_hs) r_w_state <= W_DATA;
        W_DATA: if (w_w_end) r_w_state <= W_RESP;
        W_RESP: begin
          if (w_b_hs) begin
            r_rr_wr   <= w_rr_wr_nxt;
            r_w_state <= W_IDLE;
          end
        end
        default: r_w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mux_arbiter.sv
// tb_axi_mux_arbiter: scenario bench for axi_mux_arbiter.
// Expected beats/grants are queued at stimulus and popped at output.
module tb_axi_mux_arbiter;

  localparam int NR = 2;
  localparam int NW = 2;
  localparam int MO = 2;
  localparam int IW = 4;

  logic clk, rst;
  logic [NR*32-1:0] m_araddr;
  logic [NR*4-1:0]  m_arlen;
  logic [NR*3-1:0]  m_arsize;
  logic [NR-1:0]    m_arvalid, m_arready;
  logic [NR*32-1:0] m_rdata;
  logic [NR-1:0]    m_rlast, m_rvalid, m_rready;
  logic [NW*32-1:0] m_awaddr;
  logic [NW*4-1:0]  m_awlen;
  logic [NW*3-1:0]  m_awsize;
  logic [NW-1:0]    m_awvalid, m_awready;
  logic [NW*32-1:0] m_wdata;
  logic [NW*4-1:0]  m_wstrb;
  logic [NW-1:0]    m_wlast, m_wvalid, m_wready;
  logic [NW-1:0]    m_bvalid, m_bready;
  logic [IW-1:0]    arid, rid, awid, wid, bid;
  logic [31:0]      araddr, rdata, awaddr, wdata;
  logic [3:0]       arlen, arcache, awlen, awcache, wstrb;
  logic [2:0]       arsize, arprot, awsize, awprot;
  logic [1:0]       arburst, arlock, awburst, awlock;
  logic [1:0]       rresp, bresp;
  logic arvalid, arready, rlast, rvalid, rready;
  logic awvalid, awready, wlast, wvalid, wready;
  logic bvalid, bready;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          m;
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t       rq[$];
  int          idq[$];
  logic [31:0] wq[$];

  axi_mux_arbiter #(
    .N_RD(NR), .N_WR(NW), .MAX_OUTS(MO), .ID_W(IW)
  ) dut (
    .clk(clk), .rst(rst),
    .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arvalid(m_arvalid),
    .m_arready(m_arready), .m_rdata(m_rdata),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awvalid(m_awvalid),
    .m_awready(m_awready), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache),
    .arprot(arprot), .arvalid(arvalid),
    .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache),
    .awprot(awprot), .awvalid(awvalid),
    .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid),
    .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs;
    m_araddr = '0; m_arlen = '0; m_arsize = '0;
    m_arvalid = '0; m_rready = '0;
    m_awaddr = '0; m_awlen = '0; m_awsize = '0;
    m_awvalid = '0; m_wdata = '0; m_wstrb = '0;
    m_wlast = '0; m_wvalid = '0; m_bready = '0;
    arready = 0; rid = '0; rdata = '0; rresp = '0;
    rlast = 0; rvalid = 0; awready = 0; wready = 0;
    bid = '0; bresp = '0; bvalid = 0;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Accept one AR within `bound` cycles; reports what was seen.
  task automatic wait_ar(input int bound, output bit ok,
                         output int waited,
                         output logic [IW-1:0] id,
                         output logic [31:0] addr,
                         output logic [NR-1:0] mr);
    ok = 0; waited = 0; id = '0; addr = '0; mr = '0;
    arready = 1'b1;
    for (int c = 0; c < bound; c++) begin
      #1;
      if (arvalid) begin
        id = arid; addr = araddr; mr = m_arready;
        ok = 1;
        break;
      end
      waited++;
      tick();
    end
    if (ok) tick();
    arready = 1'b0;
  endtask

  task automatic drive_r(input int id, input logic [31:0] d,
                         input logic l,
                         output logic [NR-1:0] v,
                         output logic [NR*32-1:0] dat,
                         output logic [NR-1:0] lst,
                         output logic rr);
    rid = IW'(id); rdata = d; rlast = l; rvalid = 1'b1;
    #1;
    v = m_rvalid; dat = m_rdata; lst = m_rlast; rr = rready;
    tick();
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic test_reset;
    logic [NR-1:0] v;
    rst = 1'b0;
    clear_inputs();
    tick();
    tick();
    n_checks++;
    if ({arvalid, awvalid, wvalid, bready, m_arready,
         m_awready, m_wready, m_bvalid, m_rvalid} !== '0) begin
      n_fail++;
      $display("FAIL reset_valids got %b want 0",
        {arvalid, awvalid, wvalid, bready, m_arready,
         m_awready, m_wready, m_bvalid, m_rvalid});
    end
    m_rready = 2'b01; rid = '0; rvalid = 1'b1;
    #1;
    v = m_rvalid;
    n_checks++;
    if ({v, rready} !== 3'b011) begin
      n_fail++;
      $display("FAIL reset_r_route got %b want 011", {v, rready});
    end
    n_checks++;
    if ({arburst, awburst} !== 4'b0101) begin
      n_fail++;
      $display("FAIL burst_type got %b want 0101",
               {arburst, awburst});
    end
    rvalid = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_read;
    bit ok; int w;
    logic [IW-1:0] id; logic [31:0] a; logic [NR-1:0] mr;
    logic [NR-1:0] v, lst, ev; logic [NR*32-1:0] dat, ed;
    logic rr; beat_t e;
    do_reset();
    m_arvalid = 2'b01;
    m_araddr[31:0] = 32'h1000_0040;
    m_arlen[3:0] = 4'd7;
    m_arsize[2:0] = 3'd2;
    #1;
    n_checks++;
    if (arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd1_idle_arvalid got %b want 0", arvalid);
    end
    tick();
    #1;
    n_checks++;
    if ({arvalid, arlen} !== 5'b1_0111) begin
      n_fail++;
      $display("FAIL rd1_arlen got %b want 10111",
               {arvalid, arlen});
    end
    wait_ar(4, ok, w, id, a, mr);
    m_arvalid = '0;
    n_checks++;
    if (!ok || id !== 4'd0 || a !== 32'h1000_0040 ||
        mr !== 2'b01 || w !== 0) begin
      n_fail++;
      $display("FAIL rd1_ar got ok%0d id%0d a%h mr%b w%0d want 1 0 10000040 01 0",
               ok, id, a, mr, w);
    end
    #1;
    n_checks++;
    if (m_arready !== 2'b00 || dut.r_rd_cnt[0] !== 4'd1) begin
      n_fail++;
      $display("FAIL rd1_cnt_up got mr%b cnt%0d want 00 1",
               m_arready, dut.r_rd_cnt[0]);
    end
    tick();
    m_rready = 2'b11;
    for (int b = 0; b < 8; b++) begin
      rq.push_back('{0, 32'hD000_0000 + 32'(b), b == 7});
      drive_r(0, 32'hD000_0000 + 32'(b), b == 7,
              v, dat, lst, rr);
      e = rq.pop_front();
      ev = '0; ev[e.m] = 1'b1;
      ed = '0; ed[e.m*32 +: 32] = e.d;
      n_checks++;
      if (v !== ev || dat !== ed || rr !== 1'b1 ||
          lst !== (e.l ? ev : 2'b00)) begin
        n_fail++;
        $display("FAIL rd1_beat%0d got v%b d%h l%b want v%b d%h l%0d",
                 b, v, dat, lst, ev, ed, e.l);
      end
    end
    n_checks++;
    if (dut.r_rd_cnt[0] !== 4'd0) begin
      n_fail++;
      $display("FAIL rd1_cnt_down got %0d want 0",
               dut.r_rd_cnt[0]);
    end
  endtask

  task automatic test_round_robin;
    bit ok; int w, ex;
    logic [IW-1:0] id; logic [31:0] a; logic [NR-1:0] mr;
    do_reset();
    m_arvalid = 2'b11;
    m_araddr = {32'h0000_B000, 32'h0000_A000};
    idq.push_back(0); idq.push_back(1);
    idq.push_back(0); idq.push_back(1);
    for (int i = 0; i < 4; i++) begin
      wait_ar(6, ok, w, id, a, mr);
      ex = idq.pop_front();
      n_checks++;
      if (!ok || id !== IW'(ex) || w !== 1 ||
          a !== (ex == 1 ? 32'h0000_B000 : 32'h0000_A000) ||
          mr !== NR'(1 << ex)) begin
        n_fail++;
        $display("FAIL rr_ar%0d got ok%0d id%0d a%h mr%b w%0d want id%0d w1",
                 i, ok, id, a, mr, w, ex);
      end
    end
    m_arvalid = '0;
    n_checks++;
    if (dut.r_rd_cnt[0] !== 4'd2 || dut.r_rd_cnt[1] !== 4'd2) begin
      n_fail++;
      $display("FAIL rr_cnt got %0d %0d want 2 2",
               dut.r_rd_cnt[0], dut.r_rd_cnt[1]);
    end
  endtask

  task automatic test_max_outs;
    bit ok; int w;
    logic [IW-1:0] id; logic [31:0] a; logic [NR-1:0] mr;
    logic [NR-1:0] v, lst; logic [NR*32-1:0] dat; logic rr;
    do_reset();
    m_arvalid = 2'b10;
    m_araddr[63:32] = 32'h0000_C000;
    for (int i = 0; i < 2; i++) begin
      wait_ar(6, ok, w, id, a, mr);
      n_checks++;
      if (!ok || id !== 4'd1 || mr !== 2'b10) begin
        n_fail++;
        $display("FAIL mo_ar%0d got ok%0d id%0d mr%b want 1 1 10",
                 i, ok, id, mr);
      end
    end
    wait_ar(6, ok, w, id, a, mr);
    #1;
    n_checks++;
    if (ok || arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL mo_stall got ok%0d arvalid%b want 0 0",
               ok, arvalid);
    end
    tick();
    m_rready = 2'b10;
    drive_r(1, 32'h5555_AAAA, 1'b1, v, dat, lst, rr);
    n_checks++;
    if (v !== 2'b10 || rr !== 1'b1 ||
        dat !== {32'h5555_AAAA, 32'h0}) begin
      n_fail++;
      $display("FAIL mo_rlast got v%b rr%b d%h want 10 1",
               v, rr, dat);
    end
    wait_ar(6, ok, w, id, a, mr);
    m_arvalid = '0;
    n_checks++;
    if (!ok || id !== 4'd1 || a !== 32'h0000_C000) begin
      n_fail++;
      $display("FAIL mo_resume got ok%0d id%0d a%h want 1 1 c000",
               ok, id, a);
    end
    n_checks++;
    if (dut.r_rd_cnt[1] !== 4'd2) begin
      n_fail++;
      $display("FAIL mo_cnt got %0d want 2", dut.r_rd_cnt[1]);
    end
  endtask

  task automatic test_interleave;
    bit ok; int w;
    logic [IW-1:0] id; logic [31:0] a; logic [NR-1:0] mr;
    logic [NR-1:0] v, lst, ev; logic [NR*32-1:0] dat, ed;
    logic rr; beat_t e;
    beat_t tbl[3];
    tbl[0] = '{1, 32'hE100_0001, 1'b0};
    tbl[1] = '{0, 32'hE000_0000, 1'b1};
    tbl[2] = '{1, 32'hE100_0002, 1'b1};
    do_reset();
    m_arvalid = 2'b01;
    m_araddr = {32'h0000_3000, 32'h0000_2000};
    tick();
    m_arvalid = 2'b11;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (arvalid !== 1'b1 || arid !== 4'd0 ||
          araddr !== 32'h0000_2000 || m_arready !== 2'b00) begin
        n_fail++;
        $display("FAIL il_hold%0d got v%b id%0d a%h want 1 0 2000",
                 c, arvalid, arid, araddr);
      end
      tick();
    end
    wait_ar(3, ok, w, id, a, mr);
    m_arvalid = 2'b10;
    n_checks++;
    if (!ok || id !== 4'd0 || w !== 0) begin
      n_fail++;
      $display("FAIL il_ar0 got ok%0d id%0d w%0d want 1 0 0",
               ok, id, w);
    end
    wait_ar(4, ok, w, id, a, mr);
    m_arvalid = '0;
    n_checks++;
    if (!ok || id !== 4'd1 || a !== 32'h0000_3000) begin
      n_fail++;
      $display("FAIL il_ar1 got ok%0d id%0d a%h want 1 1 3000",
               ok, id, a);
    end
    m_rready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      rq.push_back(tbl[i]);
      drive_r(tbl[i].m, tbl[i].d, tbl[i].l, v, dat, lst, rr);
      e = rq.pop_front();
      ev = '0; ev[e.m] = 1'b1;
      ed = '0; ed[e.m*32 +: 32] = e.d;
      n_checks++;
      if (v !== ev || dat !== ed || rr !== 1'b1 ||
          lst !== (e.l ? ev : 2'b00)) begin
        n_fail++;
        $display("FAIL il_beat%0d got v%b d%h l%b want v%b d%h",
                 i, v, dat, lst, ev, ed);
      end
    end
    m_rready = '0;
    drive_r(5, 32'hBAD0_0005, 1'b1, v, dat, lst, rr);
    n_checks++;
    if (v !== 2'b00 || dat !== '0 || rr !== 1'b1) begin
      n_fail++;
      $display("FAIL il_bad_rid got v%b d%h rr%b want 00 0 1",
               v, dat, rr);
    end
    n_checks++;
    if (dut.r_rd_cnt[0] !== 4'd0 || dut.r_rd_cnt[1] !== 4'd0) begin
      n_fail++;
      $display("FAIL il_cnt got %0d %0d want 0 0",
               dut.r_rd_cnt[0], dut.r_rd_cnt[1]);
    end
  endtask

  task automatic test_write;
    logic [31:0] e;
    do_reset();
    m_awvalid = 2'b11;
    m_awaddr = {32'h5000_0000, 32'h4000_0000};
    m_awlen = {4'd0, 4'd3};
    m_wvalid = 2'b11;
    m_wdata = {32'h1111_1111, 32'h2222_2222};
    m_wstrb = 8'hFF;
    wready = 1'b1;
    #1;
    n_checks++;
    if (awvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_idle_awvalid got %b want 0", awvalid);
    end
    tick();
    #1;
    n_checks++;
    if (awvalid !== 1'b1 || awid !== 4'd0 ||
        awaddr !== 32'h4000_0000 || awlen !== 4'd3 ||
        m_wready !== 2'b00 || wvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_aw0 got v%b id%0d a%h wr%b wv%b want 1 0 40000000 00 0",
               awvalid, awid, awaddr, m_wready, wvalid);
    end
    awready = 1'b1;
    #1;
    n_checks++;
    if (m_awready !== 2'b01) begin
      n_fail++;
      $display("FAIL wr_awready got %b want 01", m_awready);
    end
    tick();
    awready = 1'b0;
    for (int b = 0; b < 4; b++) wq.push_back(32'hF000_0000 + 32'(b));
    for (int b = 0; b < 4; b++) begin
      m_wdata[31:0] = 32'hF000_0000 + 32'(b);
      m_wlast[0] = (b == 3);
      #1;
      e = wq.pop_front();
      n_checks++;
      if (wdata !== e || wid !== 4'd0 || wstrb !== 4'hF ||
          {wvalid, wlast, m_wready, awvalid} !==
          {1'b1, b == 3, 2'b01, 1'b0}) begin
        n_fail++;
        $display("FAIL wr_beat%0d got d%h id%0d f%b want d%h",
                 b, wdata, wid,
                 {wvalid, wlast, m_wready, awvalid}, e);
      end
      tick();
    end
    m_wvalid = 2'b10; m_wlast = 2'b10;
    bvalid = 1'b1; bid = 4'd0; m_bready = 2'b11;
    #1;
    n_checks++;
    if (m_bvalid !== 2'b01 || bready !== 1'b1 ||
        awvalid !== 1'b0 || wvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_b0 got bv%b br%b awv%b want 01 1 0",
               m_bvalid, bready, awvalid);
    end
    tick();
    bvalid = 1'b0;
    m_awvalid = 2'b10;
    #1;
    n_checks++;
    if (awvalid !== 1'b0 || m_bvalid !== 2'b00) begin
      n_fail++;
      $display("FAIL wr_gap got awv%b bv%b want 0 00",
               awvalid, m_bvalid);
    end
    tick();
    #1;
    n_checks++;
    if (awvalid !== 1'b1 || awid !== 4'd1 ||
        awaddr !== 32'h5000_0000) begin
      n_fail++;
      $display("FAIL wr_aw1 got v%b id%0d a%h want 1 1 50000000",
               awvalid, awid, awaddr);
    end
    awready = 1'b1;
    tick();
    awready = 1'b0;
    m_awvalid = '0;
    #1;
    n_checks++;
    if (wid !== 4'd1 || wdata !== 32'h1111_1111 ||
        m_wready !== 2'b10 || wlast !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_w1 got id%0d d%h r%b l%b want 1 11111111 10 1",
               wid, wdata, m_wready, wlast);
    end
    tick();
    m_wvalid = '0;
    bvalid = 1'b1; bid = 4'd1;
    #1;
    n_checks++;
    if (m_bvalid !== 2'b10 || bready !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_b1 got bv%b br%b want 10 1",
               m_bvalid, bready);
    end
    tick();
    bvalid = 1'b0;
  endtask

  task automatic test_reset_mid_write;
    do_reset();
    m_awvalid = 2'b01;
    m_wvalid = 2'b01;
    awready = 1'b1;
    wready = 1'b1;
    tick();
    tick();
    #1;
    n_checks++;
    if (wvalid !== 1'b1 || m_wready !== 2'b01) begin
      n_fail++;
      $display("FAIL rmw_pre got wv%b wr%b want 1 01",
               wvalid, m_wready);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({awvalid, wvalid, bready, arvalid, m_wready,
         m_awready, m_bvalid, m_arready} !== '0) begin
      n_fail++;
      $display("FAIL rmw_async got %b want 0",
               {awvalid, wvalid, bready, arvalid, m_wready,
                m_awready, m_bvalid, m_arready});
    end
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (2'(dut.r_w_state) !== 2'd0 || awvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rmw_idle got st%0d awv%b want 0 0",
               dut.r_w_state, awvalid);
    end
    tick();
    #1;
    n_checks++;
    if (awvalid !== 1'b1 || awid !== 4'd0 || wvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rmw_restart got awv%b id%0d wv%b want 1 0 0",
               awvalid, awid, wvalid);
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_max_outs();
    test_interleave();
    test_write();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_mux_arbiter.md
# axi_mux_arbiter

Parametrised AXI3 master-side arbiter between the CPU's cache/uncached masters and the single external AXI port. Generalises the fixed two-master, combinational I/D read mux to N_RD read masters and N_WR write masters. Adds registered round-robin grants, a per-master outstanding-read limit, and write-channel ownership held from AW acceptance to B completion. Sits between the cache layer and the SoC AXI interconnect.

## Interface
Parameters:
- N_RD, 2, number of read masters (index 0 = I-cache, 1 = D-cache, further = uncached/prefetch); 1..8
- N_WR, 2, number of write masters; 1..8
- MAX_OUTS, 2, maximum outstanding AR transactions per read master; 1..15
- ID_W, 4, AXI ID width; must be >= clog2(max(N_RD, N_WR))

Ports (per-master signals are flattened vectors, master k in slice k):
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- m_araddr/m_arlen/m_arsize/m_arvalid  in  N_RD×32/×4/×3/×1  read address requests
- m_arready  out  N_RD  AR accepted
- m_rdata/m_rlast/m_rvalid  out  N_RD×32/×1/×1  routed read data
- m_rready  in  N_RD  read data accept
- m_awaddr/m_awlen/m_awsize/m_awvalid  in  N_WR×32/×4/×3/×1  write address requests
- m_awready  out  N_WR
- m_wdata/m_wstrb/m_wlast/m_wvalid  in  N_WR×32/×4/×1/×1
- m_wready  out  N_WR
- m_bvalid  out  N_WR;  m_bready  in  N_WR
- arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid  out; arready in  (AXI AR)
- rid, rdata, rresp, rlast, rvalid  in; rready out  (AXI R)
- awid … awvalid  out; awready in;  wid, wdata, wstrb, wlast, wvalid  out; wready in;  bid, bresp, bvalid  in; bready out

## Operation
- Constants: arburst = awburst = 2'b01 (INCR); lock/cache/prot = 0; wid = awid.
- Read arbiter FSM: RA_IDLE, RA_BUSY.
  - RA_IDLE: eligible = m_arvalid[k] && rd_cnt[k] < MAX_OUTS. Pick the first eligible index at or after rr_rd (wrapping). Register ar_gnt and go to RA_BUSY. No eligible master: stay.
  - RA_BUSY: drive arvalid = m_arvalid[ar_gnt], plus the granted master's addr/len/size; arid = ar_gnt zero-extended. On arready && arvalid: m_arready[ar_gnt] = 1 that cycle, rd_cnt[ar_gnt]++, rr_rd = ar_gnt+1 mod N_RD, return to RA_IDLE. The grant never changes while in RA_BUSY.
- R routing is combinational on rid index. m_rvalid[rid] = rvalid; rready = m_rready[rid]; other masters see rvalid = 0, rdata = 0. On rvalid && rready && rlast: rd_cnt[rid]--.
- An AR handshake and an rlast completion for the same master in the same cycle leave rd_cnt unchanged.
- rid outside 0..N_RD-1 is dropped: rready = 1, nothing routed.
- Write FSM: W_IDLE, W_ADDR, W_DATA, W_RESP.
  - W_IDLE: round-robin among m_awvalid from rr_wr; latch wr_gnt and go to W_ADDR.
  - W_ADDR: AW passthrough from wr_gnt; on awready go to W_DATA.
  - W_DATA: W passthrough; on wvalid && wready && wlast go to W_RESP.
  - W_RESP: bready = m_bready[wr_gnt], m_bvalid[wr_gnt] = bvalid; on handshake rr_wr = wr_gnt+1, go to W_IDLE.
  - One write outstanding at a time; read and write channels are fully independent.
- Non-granted masters always see ready = 0 and valid = 0.

## Timing
- Reset (rst = 0, asynchronous): FSMs go to IDLE; rr_rd = rr_wr = 0; rd_cnt = 0. All valid/ready outputs are 0 (arvalid, awvalid, wvalid, bready, m_*ready, m_*valid), except routed R signals, which follow their inputs. Reset mid-burst abandons the transaction with no recovery.
- AR latency: request at cycle t (FSM idle) → arvalid at t+1 → m_arready in the arready cycle. Best case is 2 cycles per AR, so back-to-back ARs issue every 2 cycles.
- AW: arvalid at t+1; W may begin the cycle after the AW handshake. W data presented earlier is held off (m_wready = 0).
- The grant is registered, so valid-to-grant is never combinational. AR/AW outputs have no combinational path from arready/awready.
- R/B routing adds zero latency.

## Test plan
- Single I-cache 8-beat read (arlen = 7): arid = 0, araddr passes through, m_arready[0] pulses once, 8 beats reach master 0 only, rd_cnt[0] goes 1 → 0.
- m_arvalid = 2'b11 held: grants alternate 0, 1, 0, 1 across 4 ARs; arid sequence is 0, 1, 0, 1.
- MAX_OUTS = 2, master 1 issues 3 ARs with no R returned: the third is stalled (arvalid = 0) until one rlast completes, then issues.
- Interleaved R (rid 1 beat, rid 0 beat, rid 1 last): each beat is routed correctly; arready held low for 5 cycles keeps the grant and address stable.
- Both writers request: master 0 completes AW, 4 W beats, then B before master 1 gets awvalid. bid routes to the owning master.
- Assert rst low during W_DATA: all outputs return to reset values asynchronously, FSM is in W_IDLE after release.
